// File: rtl/bus_tracer_pkg.sv
// Shared definitions for the bus line tracer controller.
// Holds the UART command opcodes, the scheduler and receiver state
// encodings, the motor driver codes and a counter-width helper.
package bus_tracer_pkg;

  // Command opcodes carried in rx_data[7:5]
  localparam logic [2:0] OP_REQ    = 3'b001;
  localparam logic [2:0] OP_CANCEL = 3'b010;
  localparam logic [2:0] OP_ARRIVE = 3'b011;
  localparam logic [2:0] OP_HALT   = 3'b100;
  localparam logic [2:0] OP_RESUME = 3'b101;

  // Motor driver pin codes
  localparam logic [1:0] MOT_FWD = 2'b01;
  localparam logic [1:0] MOT_OFF = 2'b00;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWELL  = 2'd1,
    ST_HALTED = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Bits needed to count 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first.
// Ports:
//   clk, reset (async, active-low)
//   rxd       : serial input, idle high, asynchronous to clk
//   rx_en     : one-cycle pulse when a byte with a good stop bit arrives
//   rx_data   : last good byte, held until the next one
//   frame_err : one-cycle pulse when the stop bit reads low (byte dropped)
module uart_rx_byte
  import bus_tracer_pkg::*;
#(
  parameter int BIT_CLKS = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       rx_en,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int CW = cnt_width(BIT_CLKS);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // Synchroniser flops reset to the idle level so reset release never
  // looks like a start edge. A start bit that reads high again at
  // mid-bit is treated as a glitch and the receiver goes back to idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_en     <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rxd;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      rx_en     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              rx_en   <= 1'b1;
              rx_data <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bus_tracer_ctrl.sv
// Drive and stop controller for the bus line tracer.
// Ports:
//   clk, reset (async, active-low)
//   sensor1/2  : asynchronous line sensors
//   uart_rxd   : command UART input
//   motor1/2   : 2'b01 drive, 2'b00 off
//   stop       : high while dwelling or halted
//   halted     : high while in emergency halt
//   req_flags  : per-stop pending requests
//   rx_en, rx_data, frame_err : UART receiver status
module bus_tracer_ctrl
  import bus_tracer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int PWM_PERIOD   = 500_000,
  parameter int DUTY_FAST    = 250_000,
  parameter int DUTY_SLOW    = 130_000,
  parameter int N_STOPS      = 2,
  parameter int DWELL_CYCLES = 75_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor1,
  input  logic               sensor2,
  input  logic               uart_rxd,
  output logic [1:0]         motor1,
  output logic [1:0]         motor2,
  output logic               stop,
  output logic               halted,
  output logic [N_STOPS-1:0] req_flags,
  output logic               rx_en,
  output logic [7:0]         rx_data,
  output logic               frame_err
);

  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int PW = cnt_width(PWM_PERIOD);
  localparam int DW = cnt_width(DWELL_CYCLES);
  localparam logic [PW-1:0] PWM_LAST   = PW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  sched_state_t       state;
  sched_state_t       eff_state;
  logic               s1_meta, s1, s2_meta, s2;
  logic [PW-1:0]      pwm_cnt;
  logic [DW-1:0]      dwell_cnt;
  logic [N_STOPS-1:0] dwell_mask;
  logic [N_STOPS-1:0] k_mask;
  logic [N_STOPS-1:0] flags_eff;
  logic [N_STOPS-1:0] flags_next;
  logic [2:0]         op;
  logic [4:0]         k;
  logic               k_ok;
  logic               cmd_req, cmd_cancel, cmd_arrive, cmd_halt, cmd_resume;
  logic               dwell_done;
  logic [3:0]         drive;

  uart_rx_byte #(.BIT_CLKS(BIT_CLKS)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rxd       (uart_rxd),
    .rx_en     (rx_en),
    .rx_data   (rx_data),
    .frame_err (frame_err)
  );

  // Steering table: returns {motor1, motor2} for the current PWM phase
  function automatic logic [3:0] steer(input logic a, input logic b,
                                       input logic [PW-1:0] cnt);
    int d1;
    int d2;
    case ({a, b})
      2'b11:   begin d1 = DUTY_FAST; d2 = DUTY_FAST; end
      2'b01:   begin d1 = DUTY_FAST; d2 = DUTY_SLOW; end
      2'b10:   begin d1 = DUTY_SLOW; d2 = DUTY_FAST; end
      default: begin d1 = 0;         d2 = 0;         end
    endcase
    steer = {(int'(cnt) < d1) ? MOT_FWD : MOT_OFF,
             (int'(cnt) < d2) ? MOT_FWD : MOT_OFF};
  endfunction

  // Two-flop synchronisers for the sensors plus the free-running PWM counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_meta <= 1'b0;
      s1      <= 1'b0;
      s2_meta <= 1'b0;
      s2      <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      s1_meta <= sensor1;
      s1      <= s1_meta;
      s2_meta <= sensor2;
      s2      <= s2_meta;
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
    end
  end

  assign op   = rx_data[7:5];
  assign k    = rx_data[4:0];
  assign k_ok = int'(k) < N_STOPS;

  // Commands are qualified by the rx_en pulse so each byte acts exactly once
  always_comb begin
    k_mask     = k_ok ? (N_STOPS'(1) << k) : '0;
    cmd_req    = rx_en && k_ok && (op == OP_REQ);
    cmd_cancel = rx_en && k_ok && (op == OP_CANCEL);
    cmd_arrive = rx_en && k_ok && (op == OP_ARRIVE);
    cmd_halt   = rx_en && k_ok && (op == OP_HALT);
    cmd_resume = rx_en && k_ok && (op == OP_RESUME);
    drive      = steer(s1, s2, pwm_cnt);
  end

  // Dwell expiry is folded in first, so a command landing on the expiry
  // cycle is evaluated as if the scheduler were already back in RUN.
  always_comb begin
    dwell_done = (state == ST_DWELL) && (dwell_cnt == DWELL_LAST);
    eff_state  = dwell_done ? ST_RUN : state;
    flags_eff  = dwell_done ? (req_flags & ~dwell_mask) : req_flags;
    flags_next = flags_eff;
    if (cmd_req)    flags_next = flags_eff | k_mask;
    if (cmd_cancel) flags_next = flags_eff & ~k_mask;
  end

  // Scheduler. Motors are loaded from the state being entered so they
  // switch off on the same cycle that stop/halted rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      req_flags  <= '0;
      dwell_mask <= '0;
      dwell_cnt  <= '0;
      stop       <= 1'b0;
      halted     <= 1'b0;
      motor1     <= MOT_OFF;
      motor2     <= MOT_OFF;
    end else begin
      req_flags <= flags_next;
      case (eff_state)
        ST_RUN: begin
          if (cmd_halt) begin
            state  <= ST_HALTED;
            stop   <= 1'b1;
            halted <= 1'b1;
            motor1 <= MOT_OFF;
            motor2 <= MOT_OFF;
          end else if (cmd_arrive && |(flags_eff & k_mask)) begin
            state      <= ST_DWELL;
            dwell_mask <= k_mask;
            dwell_cnt  <= '0;
            stop       <= 1'b1;
            halted     <= 1'b0;
            motor1     <= MOT_OFF;
            motor2     <= MOT_OFF;
          end else begin
            state            <= ST_RUN;
            stop             <= 1'b0;
            halted           <= 1'b0;
            {motor1, motor2} <= drive;
          end
        end
        ST_DWELL: begin
          if (cmd_halt) begin
            state  <= ST_HALTED;
            stop   <= 1'b1;
            halted <= 1'b1;
            motor1 <= MOT_OFF;
            motor2 <= MOT_OFF;
          end else if (cmd_cancel && (k_mask == dwell_mask)) begin
            state            <= ST_RUN;
            stop             <= 1'b0;
            {motor1, motor2} <= drive;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
            stop      <= 1'b1;
            motor1    <= MOT_OFF;
            motor2    <= MOT_OFF;
          end
        end
        ST_HALTED: begin
          if (cmd_resume) begin
            state            <= ST_RUN;
            stop             <= 1'b0;
            halted           <= 1'b0;
            {motor1, motor2} <= drive;
          end else begin
            stop   <= 1'b1;
            halted <= 1'b1;
            motor1 <= MOT_OFF;
            motor2 <= MOT_OFF;
          end
        end
        default: begin
          state  <= ST_RUN;
          stop   <= 1'b0;
          halted <= 1'b0;
          motor1 <= MOT_OFF;
          motor2 <= MOT_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_tracer_ctrl.sv
// Self-checking bench for bus_tracer_ctrl. Received bytes are checked
// through a scoreboard queue filled when each UART frame is driven.
// The dwell is lengthened to 150 cycles so that a second command byte
// (about 100 cycles on the wire) can land while a dwell is in progress.
module tb_bus_tracer_ctrl;

  localparam int BITC    = 10;
  localparam int NST     = 4;
  localparam int DWELL   = 150;
  localparam int PERIOD  = 10;
  localparam int FAST    = 6;
  localparam int SLOW    = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           sensor1 = 1'b1;
  logic           sensor2 = 1'b1;
  logic           uart_rxd = 1'b1;
  logic [1:0]     motor1, motor2;
  logic           stop, halted;
  logic [NST-1:0] req_flags;
  logic           rx_en;
  logic [7:0]     rx_data;
  logic           frame_err;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rx_exp_q[$];
  logic [7:0]  last_byte = 8'h00;
  logic [NST-1:0] exp_flags = '0;
  int          rx_count = 0;
  int          fe_count = 0;
  int          stop_cycles = 0;
  int          bad_motor = 0;
  int          cycle = 0;
  int          last_rx_cycle = 0;
  int          fall_cycle = 0;
  logic        prev_stop = 1'b0;

  bus_tracer_ctrl #(
    .CLK_HZ(1000), .BAUD(100), .PWM_PERIOD(PERIOD), .DUTY_FAST(FAST),
    .DUTY_SLOW(SLOW), .N_STOPS(NST), .DWELL_CYCLES(DWELL)
  ) dut (
    .clk(clk), .reset(reset), .sensor1(sensor1), .sensor2(sensor2),
    .uart_rxd(uart_rxd), .motor1(motor1), .motor2(motor2), .stop(stop),
    .halted(halted), .req_flags(req_flags), .rx_en(rx_en),
    .rx_data(rx_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one 8N1 frame starting on a falling clock edge
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    if (stop_bit) begin
      rx_exp_q.push_back(data);
      last_byte = data;
    end
    uart_rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = data[i];
      repeat (BITC) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BITC) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic countDrive(input int n, output int c1, output int c2);
    c1 = 0;
    c2 = 0;
    repeat (n) begin
      @(negedge clk);
      if (motor1 == 2'b01) c1++;
      if (motor2 == 2'b01) c2++;
    end
  endtask

  task automatic waitStopLow(input int budget, input string tag);
    int n = 0;
    while (stop && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'b0, stop}, 32'd0);
  endtask

  // Scoreboard consumer and stop/rx timing monitor
  always @(negedge clk) begin
    cycle++;
    if (rx_en) begin
      rx_count++;
      last_rx_cycle = cycle;
      if (rx_exp_q.size() == 0) checkOutput("rx_unexpected", 32'd1, 32'd0);
      else checkOutput("rx_data", {24'b0, rx_data}, {24'b0, rx_exp_q.pop_front()});
    end
    if (frame_err) fe_count++;
    if (stop) begin
      stop_cycles++;
      if (motor1 != 2'b00 || motor2 != 2'b00) bad_motor++;
    end
    if (prev_stop && !stop) fall_cycle = cycle;
    prev_stop = stop;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c1, c2, before_rx, before_fe;
    logic s1v[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic s2v[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int   d1[4]  = '{FAST, FAST, SLOW, 0};
    int   d2[4]  = '{FAST, SLOW, FAST, 0};

    // Reset state with sensors asking for full drive
    repeat (3) @(negedge clk);
    checkOutput("rst_motor1", {30'b0, motor1}, 32'd0);
    checkOutput("rst_motor2", {30'b0, motor2}, 32'd0);
    checkOutput("rst_stop", {31'b0, stop}, 32'd0);
    checkOutput("rst_halted", {31'b0, halted}, 32'd0);
    checkOutput("rst_flags", {28'b0, req_flags}, 32'd0);
    checkOutput("rst_rx", {23'b0, rx_en, rx_data}, 32'd0);
    checkOutput("rst_ferr", {31'b0, frame_err}, 32'd0);
    reset = 1'b1;

    // Steering: duty over two full PWM periods
    for (int p = 0; p < 4; p++) begin
      sensor1 = s1v[p];
      sensor2 = s2v[p];
      repeat (5) @(negedge clk);
      countDrive(2 * PERIOD, c1, c2);
      checkOutput($sformatf("steer%0d_m1", p), c1, 2 * d1[p]);
      checkOutput($sformatf("steer%0d_m2", p), c2, 2 * d2[p]);
    end
    sensor1 = 1'b1;
    sensor2 = 1'b1;

    // Request stop 2, then out-of-range request is ignored
    applyStimulus(8'h22, 1'b1);
    exp_flags = 4'b0100;
    checkOutput("req2_flags", {28'b0, req_flags}, {28'b0, exp_flags});
    applyStimulus(8'h24, 1'b1);
    checkOutput("req_oob_flags", {28'b0, req_flags}, {28'b0, exp_flags});

    // Arrive at stop 2: full-length dwell
    stop_cycles = 0;
    bad_motor = 0;
    applyStimulus(8'h62, 1'b1);
    checkOutput("arrive2_stop", {31'b0, stop}, 32'd1);
    waitStopLow(400, "dwell_timeout");
    exp_flags = 4'b0000;
    checkOutput("dwell_len", stop_cycles, DWELL);
    checkOutput("dwell_motor_off", bad_motor, 0);
    checkOutput("dwell_flags", {28'b0, req_flags}, {28'b0, exp_flags});
    countDrive(PERIOD, c1, c2);
    checkOutput("after_dwell_m1", c1, FAST);

    // Unrequested arrival
    stop_cycles = 0;
    applyStimulus(8'h61, 1'b1);
    checkOutput("unreq_stop", stop_cycles, 0);
    checkOutput("unreq_flags", {28'b0, req_flags}, 32'd0);

    // Cancel during dwell at stop 3
    applyStimulus(8'h23, 1'b1);
    stop_cycles = 0;
    applyStimulus(8'h63, 1'b1);
    checkOutput("arrive3_stop", {31'b0, stop}, 32'd1);
    applyStimulus(8'h43, 1'b1);
    checkOutput("cancel_stop", {31'b0, stop}, 32'd0);
    checkOutput("cancel_flags", {28'b0, req_flags}, 32'd0);
    checkOutput("cancel_fall_lat", fall_cycle - last_rx_cycle, 1);
    checkOutput("cancel_early", {31'b0, stop_cycles < DWELL}, 32'd1);

    // Halt during dwell at stop 1, then resume
    applyStimulus(8'h21, 1'b1);
    applyStimulus(8'h61, 1'b1);
    applyStimulus(8'h80, 1'b1);
    exp_flags = 4'b0010;
    checkOutput("halt_halted", {31'b0, halted}, 32'd1);
    checkOutput("halt_stop", {31'b0, stop}, 32'd1);
    checkOutput("halt_flags", {28'b0, req_flags}, {28'b0, exp_flags});
    checkOutput("halt_motors", {28'b0, motor1, motor2}, 32'd0);
    repeat (DWELL) @(negedge clk);
    checkOutput("halt_hold", {31'b0, halted}, 32'd1);
    checkOutput("halt_hold_flags", {28'b0, req_flags}, {28'b0, exp_flags});
    applyStimulus(8'hA0, 1'b1);
    checkOutput("resume_halted", {31'b0, halted}, 32'd0);
    checkOutput("resume_stop", {31'b0, stop}, 32'd0);
    checkOutput("resume_flags", {28'b0, req_flags}, {28'b0, exp_flags});
    countDrive(PERIOD, c1, c2);
    checkOutput("resume_m2", c2, FAST);
    applyStimulus(8'h41, 1'b1);
    checkOutput("cancel1_flags", {28'b0, req_flags}, 32'd0);

    // Bad stop bit
    before_rx = rx_count;
    before_fe = fe_count;
    applyStimulus(8'h55, 1'b0);
    checkOutput("ferr_pulse", fe_count - before_fe, 1);
    checkOutput("ferr_no_rx", rx_count - before_rx, 0);
    checkOutput("ferr_data_held", {24'b0, rx_data}, {24'b0, last_byte});

    // Short low glitch must not start a frame
    before_rx = rx_count;
    before_fe = fe_count;
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (15 * BITC) @(negedge clk);
    checkOutput("glitch_rx", rx_count - before_rx, 0);
    checkOutput("glitch_ferr", fe_count - before_fe, 0);

    // Reset in the middle of a frame while halted with a pending request
    applyStimulus(8'h20, 1'b1);
    applyStimulus(8'h80, 1'b1);
    checkOutput("pre_reset_halted", {31'b0, halted}, 32'd1);
    uart_rxd = 1'b0;
    repeat (35) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_outs", {26'b0, motor1, motor2, stop, halted},
                32'd0);
    checkOutput("midrst_flags", {28'b0, req_flags}, 32'd0);
    checkOutput("midrst_rx", {22'b0, rx_en, frame_err, rx_data}, 32'd0);
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    before_rx = rx_count;
    before_fe = fe_count;
    repeat (15 * BITC) @(negedge clk);
    checkOutput("postrst_rx", rx_count - before_rx, 0);
    checkOutput("postrst_ferr", fe_count - before_fe, 0);
    countDrive(PERIOD, c1, c2);
    checkOutput("postrst_m1", c1, FAST);

    checkOutput("rx_pending", rx_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
